wb_arbiter: RTL
===============

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIM, default 4, meaning the number of consecutive FIFO-blocked cycles before wb_stall asserts.
REQ-002 SHALL have ports, one per line: name  direction  width  meaning.
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high reset
- wb_valid  in  1  primary (pipeline writeback) write request
- wb_wa  in  5  primary destination register
- wb_wd  in  32  primary write data
- md_valid  in  1  secondary (multi-cycle unit) write request
- md_wa  in  5  secondary destination register
- md_wd  in  32  secondary write data
- md_ready  out  1  secondary FIFO can accept this cycle
- wb_stall  out  1  pipeline must hold off primary writes
- ra1, ra2  in  5 each  decode-stage read addresses for hazard check
- rd_stall  out  1  a read address targets a pending secondary write
- rf_we  out  1  register-file write enable
- rf_wa  out  5  register-file write address
- rf_wd  out  32  register-file write data
REQ-003 SHALL use one clock; reset SHALL be synchronous and active-high.

Function
REQ-004 SHALL buffer secondary writes in a 2-entry in-order FIFO, with a count of 0..2.
REQ-005 SHALL drive md_ready = (count < 2), registered, so it reflects the count after the previous edge.
REQ-006 SHALL push on md_valid && md_ready; a write with md_wa == 0 SHALL be accepted and discarded (not enqueued).
REQ-007 SHALL register rf_we, rf_wa and rf_wd, giving 1-cycle latency from selection to the register-file port.
REQ-008 SHALL resolve priority per cycle as follows:
- wb_stall high and FIFO non-empty: pop the FIFO head.
- else wb_valid && wb_wa != 0: issue primary.
- else FIFO non-empty: pop the FIFO head.
- else: rf_we = 0 next cycle.
REQ-009 SHALL drop primary writes to $0: no issue, and rf_we stays 0 unless the FIFO pops.
REQ-010 SHALL pass push and pop in the same cycle through with count unchanged; an entry pushed into an empty FIFO SHALL NOT pop in the same cycle (earliest pop is the next cycle).
REQ-011 SHALL invalidate (squash) any valid FIFO entry whose wa equals wb_wa when a primary write issues, because the newer primary write wins. Squashed entries are removed without issuing, the FIFO compacts in order, and count is updated the same edge.
REQ-012 SHALL increment a starvation counter each cycle where the FIFO is non-empty and the primary wins, and clear it on any pop or when the FIFO is empty.
REQ-013 SHALL assert wb_stall, registered, for exactly one cycle when the counter reaches STARVE_LIM, and the counter SHALL clear when that forced pop occurs.
REQ-014 SHALL treat wb_valid while wb_stall is high as a protocol violation: the primary write is ignored, with no squash and no issue.
REQ-015 SHALL compute rd_stall combinationally: asserted when (ra1 != 0 and ra1 matches any valid FIFO entry wa) or likewise for ra2.
REQ-016 SHALL NOT count the write currently on rf_* as pending, because the register file bypasses same-cycle writes.
REQ-017 SHALL NOT use the values of md_wa and md_wd when md_valid is low.

Reset
REQ-018 SHALL, while reset is high at an edge, set count = 0, invalidate all entries, clear the starvation counter, and set rf_we = 0, rf_wa = 0, rf_wd = 0, wb_stall = 0 and md_ready = 0.
REQ-019 SHALL have md_ready = 1 on the first edge after reset deasserts.
REQ-020 SHALL discard buffered writes when reset is asserted mid-operation, and SHALL issue no rf_we in that cycle's output.

Verification
REQ-021 The bench SHALL cover the following directed scenarios:
- Primary only: wb_valid, wb_wa = 5, wb_wd = 0xA5A5A5A5 -> next cycle rf_we = 1, rf_wa = 5, rf_wd = 0xA5A5A5A5.
- Secondary fill: two md pushes (wa = 3, wa = 4) with primary busy -> md_ready = 0 after the second push; rd_stall = 1 for ra1 = 4; pops occur in order 3 then 4 once primary is idle.
- Squash: FIFO holds wa = 7 (data 0x11), then primary writes wa = 7 (data 0x22) -> only 0x22 is written to reg 7; count drops to 0; rd_stall for ra1 = 7 drops the next cycle.
- Starvation: FIFO non-empty, wb_valid held with wb_wa = 9 for 4 cycles -> wb_stall high for 1 cycle, FIFO head issues, then the counter is 0.
- $0 writes: wb_wa = 0 and md_wa = 0 -> rf_we stays 0, count stays 0, rd_stall = 0 for ra1 = 0.
- Reset mid-operation: count = 2, reset pulsed -> rf_we = 0, md_ready = 0 during reset, md_ready = 1 after, and no stale entry is ever written.

Source files
------------

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: pipeline writeback has priority, multi-cycle results
// wait in a 2-entry in-order FIFO, with starvation relief and a read-hazard check.
module wb_arbiter #(
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wa,
  input  logic [31:0] wb_wd,
  input  logic        md_valid,
  input  logic [4:0]  md_wa,
  input  logic [31:0] md_wd,
  output logic        md_ready,
  output logic        wb_stall,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic        rd_stall,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  logic [4:0]    wa_q [2];
  logic [31:0]   wd_q [2];
  logic [1:0]    count_q;
  logic [SW-1:0] starve_q;
  logic          wb_stall_q, md_ready_q, rf_we_q;
  logic [4:0]    rf_wa_q;
  logic [31:0]   rf_wd_q;

  logic [4:0]    wa_d [2];
  logic [31:0]   wd_d [2];
  logic [1:0]    count_d;
  logic [SW-1:0] starve_d;
  logic          rf_we_d;
  logic [4:0]    rf_wa_d;
  logic [31:0]   rf_wd_d;

  logic push, non_empty, prim_ok, pop, keep0, keep1;

  // Only entries present at the start of the cycle can pop or be squashed; a newly
  // accepted secondary write is appended behind the survivors.
  always_comb begin
    push      = md_valid && md_ready_q && (md_wa != 5'd0);
    non_empty = (count_q != 2'd0);
    prim_ok   = !wb_stall_q && wb_valid && (wb_wa != 5'd0);
    pop       = non_empty && !prim_ok;

    keep0 = (count_q > 2'd0) && !pop && !(prim_ok && (wa_q[0] == wb_wa));
    keep1 = (count_q > 2'd1) && !(prim_ok && (wa_q[1] == wb_wa));

    wa_d    = wa_q;
    wd_d    = wd_q;
    count_d = 2'd0;
    if (keep0) count_d = 2'd1;
    if (keep1) begin
      wa_d[count_d[0]] = wa_q[1];
      wd_d[count_d[0]] = wd_q[1];
      count_d          = count_d + 2'd1;
    end
    if (push) begin
      wa_d[count_d[0]] = md_wa;
      wd_d[count_d[0]] = md_wd;
      count_d          = count_d + 2'd1;
    end

    rf_we_d = 1'b0;
    rf_wa_d = 5'd0;
    rf_wd_d = 32'd0;
    if (pop) begin
      rf_we_d = 1'b1;
      rf_wa_d = wa_q[0];
      rf_wd_d = wd_q[0];
    end else if (prim_ok) begin
      rf_we_d = 1'b1;
      rf_wa_d = wb_wa;
      rf_wd_d = wb_wd;
    end

    starve_d = starve_q;
    if (pop || (count_d == 2'd0)) starve_d = '0;
    else if (prim_ok && non_empty) starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wa_q[0]    <= 5'd0;
      wa_q[1]    <= 5'd0;
      wd_q[0]    <= 32'd0;
      wd_q[1]    <= 32'd0;
      count_q    <= 2'd0;
      starve_q   <= '0;
      wb_stall_q <= 1'b0;
      md_ready_q <= 1'b0;
      rf_we_q    <= 1'b0;
      rf_wa_q    <= 5'd0;
      rf_wd_q    <= 32'd0;
    end else begin
      wa_q       <= wa_d;
      wd_q       <= wd_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      wb_stall_q <= (starve_d == SW'(STARVE_LIM));
      md_ready_q <= (count_d < 2'd2);
      rf_we_q    <= rf_we_d;
      rf_wa_q    <= rf_wa_d;
      rf_wd_q    <= rf_wd_d;
    end
  end

  // The write currently on rf_* is already out of the FIFO, so it never stalls a read.
  function automatic logic pendingHit(input logic [4:0] a);
    return (a != 5'd0) &&
           (((count_q > 2'd0) && (wa_q[0] == a)) || ((count_q > 2'd1) && (wa_q[1] == a)));
  endfunction

  assign rd_stall = pendingHit(ra1) || pendingHit(ra2);
  assign md_ready = md_ready_q;
  assign wb_stall = wb_stall_q;
  assign rf_we    = rf_we_q;
  assign rf_wa    = rf_wa_q;
  assign rf_wd    = rf_wd_q;

endmodule
